// File: rtl/pcm_pwm_pkg.sv
// -----------------------------------------------------------------------------
// pcm_pwm_pkg
// Shared helpers for the PCM-to-PWM output stage.
//   PCM_W_MAX   : widest PCM word offset_conv() can take (left-aligned input)
//   PWM_RES_DEF : default duty resolution in bits
//   PERIOD      : carrier period in clk cycles at the default resolution
//   MIDSCALE    : duty that gives 50 % high time (silence) at the default resolution
//   offset_conv : two's complement -> offset binary on a left-aligned word
// -----------------------------------------------------------------------------
package pcm_pwm_pkg;

   localparam int PCM_W_MAX   = 32;
   localparam int PWM_RES_DEF = 8;
   localparam int PERIOD      = 1 << PWM_RES_DEF;
   localparam int MIDSCALE    = PERIOD / 2;

   // The word is passed left-aligned in PCM_W_MAX bits so one function serves
   // every PCM width: the sign bit is always bit PCM_W_MAX-1. Inverting it
   // maps two's complement onto offset binary; unsigned input passes through.
   function automatic logic [PCM_W_MAX-1:0] offset_conv(
      input logic [PCM_W_MAX-1:0] pcm,
      input logic                 signed_in
   );
      logic [PCM_W_MAX-1:0] res;
      res                = pcm;
      res[PCM_W_MAX-1]   = pcm[PCM_W_MAX-1] ^ signed_in;
      return res;
   endfunction

endpackage

// File: rtl/pcm_pwm_dac_if.sv
// -----------------------------------------------------------------------------
// pcm_pwm_dac_if
// Sample handshake between the sound core (master) and the PWM DAC (slave).
//   pcm_in    : CHANNELS packed PCM words, channel 0 in the LSBs
//   pcm_valid : source presents a sample set
//   pcm_ready : DAC holding buffer is empty; transfer on valid & ready at clk
// A source holding pcm_valid while pcm_ready is low must keep pcm_in stable.
// -----------------------------------------------------------------------------
interface pcm_pwm_dac_if #(
   parameter int CHANNELS = 2,
   parameter int PCM_W    = 16
);

   logic [CHANNELS*PCM_W-1:0] pcm_in;
   logic                      pcm_valid;
   logic                      pcm_ready;

   modport master (output pcm_in, output pcm_valid, input  pcm_ready);
   modport slave  (input  pcm_in, input  pcm_valid, output pcm_ready);

endinterface

// File: rtl/pcm_pwm_chan.sv
// -----------------------------------------------------------------------------
// pcm_pwm_chan
// One PWM channel: converts the held PCM word to a duty value at each update
// strobe and compares it against the shared carrier counter.
//   clk, rst : PWM clock, synchronous active-high reset
//   cnt      : shared carrier counter
//   update   : load a new duty (asserted on the carrier wrap cycle)
//   pcm      : raw PCM word of this channel from the holding buffer
//   pwm_out  : registered PWM bitstream, high while cnt < duty
// Optional macro PWM_SD_EN adds a first-order error-feedback requantiser so
// the time-averaged duty tracks the full PCM word; it assumes PWM_RES < PCM_W.
// -----------------------------------------------------------------------------
module pcm_pwm_chan
   import pcm_pwm_pkg::*;
#(
   parameter int PCM_W     = 16,
   parameter int PWM_RES   = PWM_RES_DEF,
   parameter bit SIGNED_IN = 1'b1,
   parameter int MID       = MIDSCALE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PWM_RES-1:0] cnt,
   input  logic               update,
   input  logic [PCM_W-1:0]   pcm,
   output logic               pwm_out
);

   localparam int ERR_W = PCM_W - PWM_RES;

   logic [PCM_W-1:0]   off;
   logic [PWM_RES-1:0] duty;
   logic [PWM_RES-1:0] duty_next;

   // Left-align into the package word, convert, then shift back down.
   assign off = PCM_W'(offset_conv(PCM_W_MAX'(pcm) << (PCM_W_MAX - PCM_W), SIGNED_IN)
                       >> (PCM_W_MAX - PCM_W));

`ifdef PWM_SD_EN
   logic [ERR_W-1:0] err;
   logic [PCM_W:0]   sum;
   logic [PCM_W-1:0] sat;

   // NOTE: every variable driven here is assigned on every pass, so no latch
   // can be inferred; keep it that way when adding terms.
   always_comb begin
      sum = {1'b0, off} + (PCM_W+1)'(err);
      sat = sum[PCM_W] ? '1 : sum[PCM_W-1:0];
   end

   // Top bits become the duty, the discarded remainder is fed into the next
   // update so it is carried rather than lost.
   assign duty_next = sat[PCM_W-1 -: PWM_RES];

   always_ff @(posedge clk) begin
      if (rst) begin
         err <= '0;
      end else if (update) begin
         err <= sat[ERR_W-1:0];
      end
   end
`else
   assign duty_next = PWM_RES'(off >> ERR_W);
`endif

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         duty    <= PWM_RES'(MID);
         pwm_out <= 1'b0;
      end else begin
         if (update) begin
            duty <= duty_next;
         end
         // Strict compare: the maximum duty still leaves one low slot.
         pwm_out <= (cnt < duty);
      end
   end

endmodule

// File: rtl/pcm_pwm_dac.sv
// -----------------------------------------------------------------------------
// pcm_pwm_dac
// Multi-channel PCM-to-PWM output stage with a shared carrier counter, a
// one-deep sample holding buffer, carrier-aligned duty updates and sticky
// underrun detection.
//   clk, rst      : PWM clock, synchronous active-high reset
//   pcm           : sample handshake (pcm_pwm_dac_if, slave side)
//   pwm_out       : CHANNELS registered PWM bitstreams
//   period_start  : one-cycle pulse aligned with the first slot of a period
//   underrun      : sticky, a period ended with no fresh sample after priming
//   underrun_clr  : clears underrun (a simultaneous set wins)
// Optional macro PWM_SD_EN enables noise-shaped requantisation per channel;
// with it, the held sample is re-run through the error feedback on underrun.
// -----------------------------------------------------------------------------
module pcm_pwm_dac
   import pcm_pwm_pkg::*;
#(
   parameter int CHANNELS  = 2,
   parameter int PCM_W     = 16,
   parameter int PWM_RES   = PWM_RES_DEF,
   parameter bit SIGNED_IN = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   pcm_pwm_dac_if.slave        pcm,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_start,
   output logic                underrun,
   input  logic                underrun_clr
);

   localparam int MID = 1 << (PWM_RES - 1);

   logic [PWM_RES-1:0]        cnt;
   logic                      hold_full;
   logic                      primed;
   logic [CHANNELS*PCM_W-1:0] hold_data;

   logic wrap;
   logic accept;
   logic starve;
   logic update;

   assign wrap          = (cnt == '1);
   assign pcm.pcm_ready = ~hold_full;
   assign accept        = pcm.pcm_valid & ~hold_full;
   // A wrap with an empty buffer after the first sample is an underrun.
   assign starve        = wrap & ~hold_full & primed;
   // Duty update on every wrap once primed: a fresh sample loads new duties;
   // an empty buffer re-presents the previous sample, which leaves a plain
   // truncated duty unchanged and keeps the requantiser's feedback running.
   assign update        = wrap & (hold_full | primed);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         hold_full    <= 1'b0;
         primed       <= 1'b0;
         underrun     <= 1'b0;
         period_start <= 1'b0;
      end else begin
         cnt          <= cnt + PWM_RES'(1);
         period_start <= (cnt == '0);

         // accept needs an empty buffer and the wrap only drains a full one,
         // so the two never coincide on the same buffer state.
         if (accept) begin
            hold_full <= 1'b1;
         end else if (wrap) begin
            hold_full <= 1'b0;
         end

         if (accept) begin
            primed <= 1'b1;
         end

         if (starve) begin
            underrun <= 1'b1;
         end else if (underrun_clr) begin
            underrun <= 1'b0;
         end
      end
   end

   // NOTE: sample storage carries no reset; hold_full/primed gate every use,
   // so stale contents after reset are never observed.
   always_ff @(posedge clk) begin
      if (accept) begin
         hold_data <= pcm.pcm_in;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      pcm_pwm_chan #(
         .PCM_W     (PCM_W),
         .PWM_RES   (PWM_RES),
         .SIGNED_IN (SIGNED_IN),
         .MID       (MID)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .cnt     (cnt),
         .update  (update),
         .pcm     (hold_data[c*PCM_W +: PCM_W]),
         .pwm_out (pwm_out[c])
      );
   end

endmodule

// File: tb/tb_pcm_pwm_dac.sv
// -----------------------------------------------------------------------------
// tb_pcm_pwm_dac
// Self-checking bench for pcm_pwm_dac (CHANNELS=2, PCM_W=16, PWM_RES=4,
// SIGNED_IN=1). A cycle model built from period/phase arithmetic predicts
// every output; directed scenarios add period-level counts on top.
// Honours PWM_SD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_pcm_pwm_dac;

   localparam int CHANNELS  = 2;
   localparam int PCM_W     = 16;
   localparam int PWM_RES   = 4;
   localparam bit SIGNED_IN = 1'b1;
   localparam int PERIOD    = 1 << PWM_RES;
   localparam int STEP_DIV  = 1 << (PCM_W - PWM_RES);
   localparam int PCM_MAX   = (1 << PCM_W) - 1;
`ifdef PWM_SD_EN
   localparam bit SD = 1'b1;
`else
   localparam bit SD = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                underrun_clr = 1'b0;
   logic [CHANNELS-1:0] pwm_out;
   logic                period_start;
   logic                underrun;

   pcm_pwm_dac_if #(.CHANNELS(CHANNELS), .PCM_W(PCM_W)) pcm_bus ();

   pcm_pwm_dac #(
      .CHANNELS  (CHANNELS),
      .PCM_W     (PCM_W),
      .PWM_RES   (PWM_RES),
      .SIGNED_IN (SIGNED_IN)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pcm          (pcm_bus),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // model state
   int                  m_phase;
   bit                  m_full, m_primed, m_underrun;
   int                  m_duty [CHANNELS];
   int                  m_err  [CHANNELS];
   logic [PCM_W-1:0]    m_word [CHANNELS];
   logic [CHANNELS-1:0] exp_pwm;
   bit                  exp_ps;

   // period-level observations
   int hi_cnt [CHANNELS];
   int ps_cnt;
   int acc_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Two's complement to offset binary is adding half scale modulo 2^PCM_W.
   function automatic int offset_of(input logic [PCM_W-1:0] w);
      if (SIGNED_IN) return (int'(w) + (1 << (PCM_W - 1))) % (1 << PCM_W);
      return int'(w);
   endfunction

   task automatic model_new_duty(input int c);
      int s;
      s = offset_of(m_word[c]);
      if (SD) begin
         s = s + m_err[c];
         if (s > PCM_MAX) s = PCM_MAX;
         m_err[c] = s % STEP_DIV;
      end
      m_duty[c] = s / STEP_DIV;
   endtask

   // Advance the model across one rising edge using the current inputs.
   task automatic model_edge();
      bit acc, wrap;
      acc = pcm_bus.pcm_valid && !m_full;
      if (rst) begin
         m_phase = 0; m_full = 0; m_primed = 0; m_underrun = 0;
         exp_pwm = '0; exp_ps = 0;
         for (int c = 0; c < CHANNELS; c++) begin
            m_duty[c] = PERIOD / 2;
            m_err[c]  = 0;
         end
         return;
      end
      wrap = (m_phase == PERIOD - 1);
      for (int c = 0; c < CHANNELS; c++) exp_pwm[c] = (m_phase < m_duty[c]);
      exp_ps = (m_phase == 0);
      if (wrap && (m_full || m_primed))
         for (int c = 0; c < CHANNELS; c++) model_new_duty(c);
      if (wrap && !m_full && m_primed) m_underrun = 1;
      else if (underrun_clr)           m_underrun = 0;
      if (wrap) m_full = 0;
      if (acc) begin
         m_full = 1; m_primed = 1;
         for (int c = 0; c < CHANNELS; c++) m_word[c] = pcm_bus.pcm_in[c*PCM_W +: PCM_W];
      end
      m_phase = (m_phase + 1) % PERIOD;
   endtask

   task automatic step();
      if (pcm_bus.pcm_valid && pcm_bus.pcm_ready && !rst) acc_seen++;
      model_edge();
      @(posedge clk);
      #1;
      check("pwm_out",      32'(pwm_out),           32'(exp_pwm));
      check("period_start", 32'(period_start),      32'(exp_ps));
      check("underrun",     32'(underrun),          32'(m_underrun));
      check("pcm_ready",    32'(pcm_bus.pcm_ready), 32'(!m_full));
   endtask

   // Step until the next edge will show slot 0 of a period.
   task automatic align();
      for (int i = 0; i < PERIOD && m_phase != 0; i++) step();
   endtask

   // One full period of output slots; pulses underrun_clr at one pre-edge phase.
   task automatic run_period(input int clr_phase);
      for (int c = 0; c < CHANNELS; c++) hi_cnt[c] = 0;
      ps_cnt   = 0;
      acc_seen = 0;
      for (int i = 0; i < PERIOD; i++) begin
         underrun_clr = (m_phase == clr_phase);
         step();
         for (int c = 0; c < CHANNELS; c++) hi_cnt[c] += int'(pwm_out[c]);
         ps_cnt += int'(period_start);
      end
      underrun_clr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; pcm_bus.pcm_valid = 1'b0; underrun_clr = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sd_exp [4];
      pcm_bus.pcm_valid = 1'b0;
      pcm_bus.pcm_in    = '0;

      // Reset state and idle midscale.
      do_reset();
      check("rst_ready",    32'(pcm_bus.pcm_ready), 32'd1);
      check("rst_pwm",      32'(pwm_out),           32'd0);
      check("rst_underrun", 32'(underrun),          32'd0);
      check("rst_ps",       32'(period_start),      32'd0);
      for (int p = 0; p < 3; p++) begin
         run_period(-1);
         check("idle_hi0", hi_cnt[0], 8);
         check("idle_hi1", hi_cnt[1], 8);
         check("idle_ps",  ps_cnt,    1);
         check("idle_underrun", 32'(underrun), 32'd0);
      end

      // Full-scale extremes: ch0=0x7FFF, ch1=0x8000.
      pcm_bus.pcm_in    = 32'h8000_7FFF;
      pcm_bus.pcm_valid = 1'b1;
      step();
      pcm_bus.pcm_valid = 1'b0;
      align();
      run_period(-1);
      check("max_hi0", hi_cnt[0], 15);
      check("min_hi1", hi_cnt[1], 0);

      // Continuous valid with fresh random data at every accept.
      do_reset();
      pcm_bus.pcm_valid = 1'b1;
      for (int p = 0; p < 4; p++) begin
         acc_seen = 0;
         for (int i = 0; i < PERIOD; i++) begin
            if (pcm_bus.pcm_ready) pcm_bus.pcm_in = (CHANNELS*PCM_W)'($urandom());
            step();
         end
         check("accepts_per_period", acc_seen, 1);
      end
      pcm_bus.pcm_valid = 1'b0;

      // One sample then starvation, with underrun_clr on and off the wrap.
      do_reset();
      pcm_bus.pcm_in    = 32'h4000_4000;
      pcm_bus.pcm_valid = 1'b1;
      step();
      pcm_bus.pcm_valid = 1'b0;
      align();
      check("starve_wrap1_underrun", 32'(underrun), 32'd0);
      run_period(-1);
      check("starve_hi0", hi_cnt[0], 12);
      check("starve_wrap2_underrun", 32'(underrun), 32'd1);
      run_period(PERIOD - 1);
      check("held_hi1", hi_cnt[1], 12);
      check("clr_on_wrap_underrun", 32'(underrun), 32'd1);
      for (int i = 0; i < PERIOD && m_phase != 3; i++) step();
      underrun_clr = 1'b1;
      step();
      underrun_clr = 1'b0;
      check("clr_off_wrap_underrun", 32'(underrun), 32'd0);

      // Reset mid-period with a full holding buffer.
      do_reset();
      pcm_bus.pcm_in    = 32'h7000_7000;
      pcm_bus.pcm_valid = 1'b1;
      step();
      pcm_bus.pcm_valid = 1'b0;
      for (int i = 0; i < PERIOD && m_phase != 7; i++) step();
      check("pre_rst_ready", 32'(pcm_bus.pcm_ready), 32'd0);
      rst = 1'b1;
      step();
      check("mid_rst_pwm",   32'(pwm_out),           32'd0);
      check("mid_rst_ready", 32'(pcm_bus.pcm_ready), 32'd1);
      rst = 1'b0;
      for (int p = 0; p < 2; p++) begin
         run_period(-1);
         check("post_rst_hi0", hi_cnt[0], 8);
         check("post_rst_hi1", hi_cnt[1], 8);
      end

      // Constant 0x0800: requantiser dithers 8/9, truncation stays at 8.
      if (SD) sd_exp = '{8, 9, 8, 9};
      else    sd_exp = '{8, 8, 8, 8};
      do_reset();
      pcm_bus.pcm_in    = 32'h0800_0800;
      pcm_bus.pcm_valid = 1'b1;
      run_period(-1);
      for (int p = 0; p < 4; p++) begin
         run_period(-1);
         check("const_hi0", hi_cnt[0], sd_exp[p]);
         check("const_hi1", hi_cnt[1], sd_exp[p]);
      end
      pcm_bus.pcm_valid = 1'b0;

      // Randomized traffic, clears and occasional resets against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (!pcm_bus.pcm_valid || pcm_bus.pcm_ready) begin
            pcm_bus.pcm_valid = ($urandom_range(0, 2) == 0);
            pcm_bus.pcm_in    = (CHANNELS*PCM_W)'($urandom());
         end
         underrun_clr = ($urandom_range(0, 7) == 0);
         rst          = ($urandom_range(0, 149) == 0);
         step();
      end
      rst = 1'b0; underrun_clr = 1'b0; pcm_bus.pcm_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
